// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM BIST controller: FSM encoding,
// display filler nibble and the expected-pattern generator.
package eeprom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [3:0] DISP_FILL = 4'hA;

  // Pattern byte for a given index and generation; 8-bit wrap is intended.
  function automatic logic [7:0] exp_byte(input logic [7:0] seed,
                                          input logic [7:0] idx,
                                          input logic [7:0] gen);
    return seed + idx + gen;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchroniser for one active-low push key plus a falling-edge
// detector; press is a single-cycle pulse per key-down event.
module key_edge (
  input  logic sys_clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  // Shift chain: raw key -> meta -> sync -> prev.
  always_comb begin
    meta_d = key_n;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Flops idle at the released (high) level so reset never looks like a press.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign press = prev_q & ~sync_q;

endmodule

// File: rtl/eeprom_bist_ctrl.sv
// EEPROM write/verify BIST controller.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_IDLE     | waiting for key; leaves at once if power-on write pending
//   ST_WR_ISSUE | wait for ee_ready, pulse write request for byte idx
//   ST_WR_WAIT  | wait for ee_ready low->high; then next byte or IDLE
//   ST_RD_ISSUE | wait for ee_ready, pulse read request for byte idx
//   ST_RD_WAIT  | wait for read strobe, compare; then next byte or DONE
//   ST_DONE     | verify finished (or timed out), pass/err results held
//
// Request/valid/address outputs are driven combinationally only in the
// accepting issue cycle, so an asserted reset silences them immediately.
module eeprom_bist_ctrl
  import eeprom_pkg::*;
#(
  parameter int         N_BYTES   = 4,
  parameter logic [7:0] BASE_ADDR = 8'h03,
  parameter logic [7:0] SEED      = 8'hC3,
  parameter int         TIMEOUT   = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [3:0]  key_in,
  input  logic        ee_ready,
  output logic        ee_wr_req,
  output logic        ee_rd_req,
  output logic [7:0]  ee_addr,
  output logic        ee_addr_vld,
  output logic [7:0]  ee_wr_data,
  output logic        ee_wr_data_vld,
  input  logic [7:0]  ee_rd_data,
  input  logic        ee_rd_data_vld,
  output logic [31:0] disp_digits,
  output logic        busy,
  output logic        pass,
  output logic        timeout_err,
  output logic [4:0]  err_cnt
);

  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0] press;
  logic       unused_key3;

  assign unused_key3 = key_in[3];

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_edge u_key (
      .sys_clk (sys_clk),
      .rst     (rst),
      .key_n   (key_in[k]),
      .press   (press[k])
    );
  end

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      gen_q, gen_d;
  logic [7:0]      sel_q, sel_d;
  logic [4:0]      err_q, err_d;
  logic            pass_q, pass_d;
  logic            tmo_q, tmo_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            seen_low_q, seen_low_d;
  logic            auto_q, auto_d;
  logic [7:0]      rd_buf_q [N_BYTES];
  logic [7:0]      rd_buf_d [N_BYTES];

  logic [7:0]      idx8, cur_addr, cur_exp, sel_exp;
  logic            last_byte;

  assign idx8      = 8'(idx_q);
  assign cur_addr  = BASE_ADDR + idx8;
  assign cur_exp   = exp_byte(SEED, idx8, gen_q);
  assign last_byte = (idx_q == IW'(N_BYTES - 1));

  // Display index: key2 steps through the bytes in any state, wrapping.
  always_comb begin
    sel_d = sel_q;
    if (press[2]) begin
      sel_d = (sel_q == 8'(N_BYTES - 1)) ? 8'd0 : sel_q + 8'd1;
    end
  end

  // Sequencer next-state, datapath updates and issue-cycle outputs.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    gen_d          = gen_q;
    err_d          = err_q;
    pass_d         = pass_q;
    tmo_d          = tmo_q;
    tmr_d          = tmr_q;
    seen_low_d     = seen_low_q;
    auto_d         = auto_q;
    rd_buf_d       = rd_buf_q;
    ee_wr_req      = 1'b0;
    ee_rd_req      = 1'b0;
    ee_addr_vld    = 1'b0;
    ee_wr_data_vld = 1'b0;
    ee_addr        = 8'd0;
    ee_wr_data     = 8'd0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Power-on write wins; key1 beats key0 when both arrive together.
        if (state_q == ST_IDLE && auto_q) begin
          auto_d  = 1'b0;
          idx_d   = '0;
          pass_d  = 1'b0;
          state_d = ST_WR_ISSUE;
        end else if (press[1]) begin
          gen_d   = gen_q + 8'd1;
          idx_d   = '0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = ST_WR_ISSUE;
        end else if (press[0]) begin
          idx_d   = '0;
          err_d   = 5'd0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = ST_RD_ISSUE;
        end
      end

      ST_WR_ISSUE: begin
        if (ee_ready) begin
          ee_wr_req      = 1'b1;
          ee_wr_data_vld = 1'b1;
          ee_addr_vld    = 1'b1;
          ee_addr        = cur_addr;
          ee_wr_data     = cur_exp;
          tmr_d          = TW'(TIMEOUT - 1);
          seen_low_d     = 1'b0;
          state_d        = ST_WR_WAIT;
        end
      end

      ST_WR_WAIT: begin
        if (!ee_ready) begin
          seen_low_d = 1'b1;
        end
        if (seen_low_q && ee_ready) begin
          if (last_byte) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_WR_ISSUE;
          end
        end else if (tmr_q == '0) begin
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end

      ST_RD_ISSUE: begin
        if (ee_ready) begin
          ee_rd_req   = 1'b1;
          ee_addr_vld = 1'b1;
          ee_addr     = cur_addr;
          tmr_d       = TW'(TIMEOUT - 1);
          state_d     = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (ee_rd_data_vld) begin
          rd_buf_d[idx_q] = ee_rd_data;
          if (ee_rd_data != cur_exp && err_q != 5'd31) begin
            err_d = err_q + 5'd1;
          end
          if (last_byte) begin
            pass_d  = (err_d == 5'd0) && !tmo_q;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_RD_ISSUE;
          end
        end else if (tmr_q == '0) begin
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset leaves the power-on write pending.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      gen_q      <= 8'd0;
      sel_q      <= 8'd0;
      err_q      <= 5'd0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
      tmr_q      <= '0;
      seen_low_q <= 1'b0;
      auto_q     <= 1'b1;
      for (int k = 0; k < N_BYTES; k++) rd_buf_q[k] <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gen_q      <= gen_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      tmr_q      <= tmr_d;
      seen_low_q <= seen_low_d;
      auto_q     <= auto_d;
      rd_buf_q   <= rd_buf_d;
    end
  end

  assign sel_exp     = exp_byte(SEED, sel_q, gen_q);
  assign disp_digits = {sel_q[7:4], sel_q[3:0], DISP_FILL, DISP_FILL,
                        sel_exp[7:4], sel_exp[3:0],
                        rd_buf_q[sel_q[IW-1:0]][7:4], rd_buf_q[sel_q[IW-1:0]][3:0]};

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign pass        = pass_q;
  assign timeout_err = tmo_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_eeprom_bist_ctrl.sv
// Directed bench for eeprom_bist_ctrl with a small EEPROM engine model.
module tb_eeprom_bist_ctrl;

  localparam int TMO = 40;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_in = 4'hF;
  logic        ee_ready;
  logic        ee_wr_req, ee_rd_req, ee_addr_vld, ee_wr_data_vld;
  logic [7:0]  ee_addr, ee_wr_data, ee_rd_data;
  logic        ee_rd_data_vld;
  logic [31:0] disp_digits;
  logic        busy, pass, timeout_err;
  logic [4:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  eeprom_bist_ctrl #(
    .N_BYTES   (4),
    .BASE_ADDR (8'h03),
    .SEED      (8'hC3),
    .TIMEOUT   (TMO)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .key_in         (key_in),
    .ee_ready       (ee_ready),
    .ee_wr_req      (ee_wr_req),
    .ee_rd_req      (ee_rd_req),
    .ee_addr        (ee_addr),
    .ee_addr_vld    (ee_addr_vld),
    .ee_wr_data     (ee_wr_data),
    .ee_wr_data_vld (ee_wr_data_vld),
    .ee_rd_data     (ee_rd_data),
    .ee_rd_data_vld (ee_rd_data_vld),
    .disp_digits    (disp_digits),
    .busy           (busy),
    .pass           (pass),
    .timeout_err    (timeout_err),
    .err_cnt        (err_cnt)
  );

  // EEPROM engine model: busy for a few cycles per request, optional hang,
  // optional corruption of one address on read-back.
  logic [7:0] mem [256];
  logic [7:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  int         n_wr = 0;
  int         n_rd = 0;
  logic [2:0] cnt;
  logic       pend_rd;
  logic [7:0] rd_addr;
  logic       hang = 1'b0;
  logic [7:0] corrupt_addr = 8'hFF;

  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ee_ready       <= 1'b1;
      cnt            <= 3'd0;
      pend_rd        <= 1'b0;
      rd_addr        <= 8'd0;
      ee_rd_data     <= 8'd0;
      ee_rd_data_vld <= 1'b0;
    end else begin
      ee_rd_data_vld <= 1'b0;
      if (ee_wr_req) begin
        ee_ready      <= 1'b0;
        cnt           <= 3'd3;
        mem[ee_addr]  <= ee_wr_data;
        if (n_wr < 64) begin
          wr_addr_log[n_wr] <= ee_addr;
          wr_data_log[n_wr] <= ee_wr_data;
        end
        n_wr <= n_wr + 1;
      end else if (ee_rd_req) begin
        ee_ready <= 1'b0;
        cnt      <= 3'd3;
        pend_rd  <= 1'b1;
        rd_addr  <= ee_addr;
        n_rd     <= n_rd + 1;
      end else if (!ee_ready && !hang) begin
        if (cnt == 3'd0) begin
          ee_ready <= 1'b1;
          if (pend_rd) begin
            pend_rd        <= 1'b0;
            ee_rd_data_vld <= 1'b1;
            ee_rd_data     <= (rd_addr == corrupt_addr) ? 8'h00 : mem[rd_addr];
          end
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge sys_clk);
    key_in = ~mask;
    repeat (4) @(negedge sys_clk);
    key_in = 4'hF;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 2000) begin
      @(negedge sys_clk);
      k++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  logic [7:0] wa_exp [4];
  logic [7:0] wd_g0  [4];
  logic [7:0] wd_g1  [4];
  int base, rbase, k, cyc;
  logic acc, found;

  initial begin
    wa_exp = '{8'h03, 8'h04, 8'h05, 8'h06};
    wd_g0  = '{8'hC3, 8'hC4, 8'hC5, 8'hC6};
    wd_g1  = '{8'hC4, 8'hC5, 8'hC6, 8'hC7};

    // Reset values
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pass", 32'(pass), 32'h0);
    chk("rst_tmo", 32'(timeout_err), 32'h0);
    chk("rst_err", 32'(err_cnt), 32'h0);
    chk("rst_reqs", 32'({ee_wr_req, ee_rd_req, ee_addr_vld, ee_wr_data_vld}), 32'h0);
    chk("rst_addr", 32'(ee_addr), 32'h0);
    chk("rst_wdata", 32'(ee_wr_data), 32'h0);
    chk("rst_disp", disp_digits, 32'h00AAC300);

    // Power-on write of four bytes
    @(negedge sys_clk);
    rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    wait_idle("powerup");
    chk("pu_nwr", 32'(n_wr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pu_addr%0d", i), 32'(wr_addr_log[i]), 32'(wa_exp[i]));
      chk($sformatf("pu_data%0d", i), 32'(wr_data_log[i]), 32'(wd_g0[i]));
    end
    chk("pu_nrd", 32'(n_rd), 32'd0);
    chk("pu_avld", 32'(ee_addr_vld), 32'h0);

    // Clean verify
    press(4'b0001);
    wait_idle("rd1");
    chk("rd1_pass", 32'(pass), 32'h1);
    chk("rd1_err", 32'(err_cnt), 32'h0);
    chk("rd1_disp", disp_digits, 32'h00AAC3C3);
    chk("rd1_nrd", 32'(n_rd), 32'd4);

    // Verify with byte 2 corrupted, then step display to index 2
    corrupt_addr = 8'h05;
    press(4'b0001);
    wait_idle("rd2");
    corrupt_addr = 8'hFF;
    chk("rd2_err", 32'(err_cnt), 32'h1);
    chk("rd2_pass", 32'(pass), 32'h0);
    press(4'b0100);
    press(4'b0100);
    chk("rd2_disp", disp_digits, 32'h02AAC500);

    // key0 and key1 together: rewrite with gen=1, no read
    base  = n_wr;
    rbase = n_rd;
    press(4'b0011);
    wait_idle("both");
    chk("both_nwr", 32'(n_wr - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("both_addr%0d", i), 32'(wr_addr_log[base + i]), 32'(wa_exp[i]));
      chk($sformatf("both_data%0d", i), 32'(wr_data_log[base + i]), 32'(wd_g1[i]));
    end
    chk("both_nrd", 32'(n_rd - rbase), 32'd0);
    chk("both_err", 32'(err_cnt), 32'h1);
    chk("both_disp", disp_digits, 32'h02AAC600);

    // key1 (gen=2) then key0 while busy: key0 must be dropped
    base  = n_wr;
    rbase = n_rd;
    press(4'b0010);
    chk("ign_busy", 32'(busy), 32'h1);
    press(4'b0001);
    wait_idle("ign");
    repeat (10) @(negedge sys_clk);
    chk("ign_nwr", 32'(n_wr - base), 32'd4);
    chk("ign_data0", 32'(wr_data_log[base]), 32'h000000C5);
    chk("ign_nrd", 32'(n_rd - rbase), 32'd0);
    chk("ign_disp", disp_digits, 32'h02AAC700);

    // Timeout: engine never returns ready after a write request (gen=3)
    hang = 1'b1;
    base = n_wr;
    @(negedge sys_clk);
    key_in = 4'b1101;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ee_wr_req === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    chk("tmo_req_seen", 32'(found), 32'h1);
    cyc = 0;
    while (timeout_err !== 1'b1 && cyc < 200) begin
      @(negedge sys_clk);
      key_in = 4'hF;
      cyc++;
    end
    key_in = 4'hF;
    chk("tmo_flag", 32'(timeout_err), 32'h1);
    chk("tmo_window", 32'(cyc >= TMO && cyc <= TMO + 2), 32'h1);
    chk("tmo_busy", 32'(busy), 32'h0);
    chk("tmo_pass", 32'(pass), 32'h0);
    chk("tmo_nwr", 32'(n_wr - base), 32'd1);
    chk("tmo_data", 32'(wr_data_log[base]), 32'h000000C6);
    hang = 1'b0;
    repeat (10) @(negedge sys_clk);

    // Verify after timeout: flag clears, three stale bytes mismatch
    press(4'b0001);
    wait_idle("rd3");
    chk("rd3_tmo", 32'(timeout_err), 32'h0);
    chk("rd3_err", 32'(err_cnt), 32'h3);
    chk("rd3_pass", 32'(pass), 32'h0);
    chk("rd3_disp", disp_digits, 32'h02AAC8C7);
    press(4'b0100);
    press(4'b0100);
    chk("wrap_disp", disp_digits, 32'h00AAC6C6);

    // Reset during RD_WAIT
    base = n_wr;
    @(negedge sys_clk);
    key_in = 4'b1110;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ee_rd_req === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    chk("mid_req_seen", 32'(found), 32'h1);
    @(negedge sys_clk);
    chk("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    key_in = 4'hF;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_reqs", 32'({ee_wr_req, ee_rd_req, ee_addr_vld, ee_wr_data_vld}), 32'h0);
    chk("mid_rst_disp", disp_digits, 32'h00AAC300);
    chk("mid_rst_err", 32'(err_cnt), 32'h0);
    acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      acc = acc | ee_wr_req | ee_rd_req | ee_addr_vld | ee_wr_data_vld;
    end
    chk("mid_rst_quiet", 32'(acc), 32'h0);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (ee_wr_req === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("re_req_seen", 32'(found), 32'h1);
    chk("re_addr", 32'(ee_addr), 32'h03);
    chk("re_data", 32'(ee_wr_data), 32'hC3);
    chk("re_dvld", 32'(ee_wr_data_vld), 32'h1);
    wait_idle("re");
    chk("re_nwr", 32'(n_wr - base), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eeprom_bist_ctrl.md
EEPROM_BIST_CTRL -- requirements
Module: eeprom_bist_ctrl

Interface
REQ-001 Parameter N_BYTES, 4, number of consecutive EEPROM bytes written/verified (1..16).
REQ-002 Parameter BASE_ADDR, 8'h03, first EEPROM register address.
REQ-003 Parameter SEED, 8'hC3, pattern seed.
REQ-004 Parameter TIMEOUT, 1_000_000, max cycles waited per EEPROM transaction.
REQ-005 sys_clk  in  1  single system clock, all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 key_in  in  4  active-low, asynchronous push keys; [0]=verify, [1]=rewrite, [2]=next index, [3] unused.
REQ-008 ee_ready  in  1  EEPROM engine idle.
REQ-009 ee_wr_req / ee_rd_req  out  1 each  one-cycle transaction requests.
REQ-010 ee_addr  out  8  register address; ee_addr_vld out 1 qualifies it.
REQ-011 ee_wr_data  out  8  write byte; ee_wr_data_vld out 1 pulses with ee_wr_req.
REQ-012 ee_rd_data  in  8, ee_rd_data_vld  in  1  read byte and its one-cycle strobe.
REQ-013 disp_digits  out  32  eight nibbles for the 7-segment driver, MSB nibble = leftmost digit.
REQ-014 busy  out  1; pass  out  1; timeout_err  out  1; err_cnt  out  5.

Function
REQ-015 Keys SHALL be 2-flop synchronised; a press is a 1->0 edge of the synchronised key.
REQ-016 Expected byte i SHALL be (SEED + i + gen) mod 256; gen is an 8-bit generation counter, wrapping 255->0.
REQ-017 FSM states: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE.
REQ-018 After reset release, the FSM SHALL enter WR_ISSUE automatically (power-on write of all N_BYTES).
REQ-019 WR_ISSUE: when ee_ready=1, assert ee_wr_req, ee_wr_data_vld for exactly one cycle with ee_addr=BASE_ADDR+i, then go to WR_WAIT.
REQ-020 WR_WAIT: completion = ee_ready seen low then high again; then i++, back to WR_ISSUE, or IDLE after i=N_BYTES-1.
REQ-021 Key1 press in IDLE or DONE: gen++, i=0, go to WR_ISSUE; key0 press: i=0, err_cnt=0, go to RD_ISSUE.
REQ-022 Simultaneous key0 and key1 presses: key1 wins; key0 discarded.
REQ-023 Key0/key1 presses while busy SHALL be ignored (not queued).
REQ-024 RD_ISSUE: when ee_ready=1, one-cycle ee_rd_req with ee_addr; RD_WAIT until ee_rd_data_vld.
REQ-025 On ee_rd_data_vld: store byte in rd_buf[i]; if mismatch with expected, err_cnt++ (saturating at 31); after last byte go to DONE.
REQ-026 DONE: pass=1 iff err_cnt=0 and timeout_err=0; pass SHALL clear on entering any write or read sequence.
REQ-027 Any WAIT state exceeding TIMEOUT cycles SHALL set timeout_err, drop the transaction, go to DONE; timeout_err clears on next key0/key1 sequence start.
REQ-028 busy=1 in every state except IDLE and DONE.
REQ-029 ee_addr_vld SHALL be 1 only in the issue cycle.
REQ-030 Key2 press: display index sel++ wrapping N_BYTES-1->0, accepted in any state.
REQ-031 disp_digits = {sel[7:4], sel[3:0], 4'hA, 4'hA, exp[sel][7:4], exp[sel][3:0], rd_buf[sel][7:4], rd_buf[sel][3:0]}.

Reset
REQ-032 On rst: FSM=IDLE with auto-write pending, i=0, gen=0, sel=0, rd_buf all 0, err_cnt=0, all request/valid outputs 0, busy=0, pass=0, timeout_err=0, ee_addr=0, ee_wr_data=0.
REQ-033 Reset mid-transaction SHALL abort immediately; no further request pulses until reset released.

Structure
REQ-034 FSM state encoding and the display filler nibble (4'hA) SHALL live in shared package eeprom_pkg.
REQ-035 Key synchroniser/edge detector SHALL be one sub-module, key_edge, instantiated per key.

Verification
REQ-036 Reset release, ee_ready model responds -> 4 writes to 0x03..0x06 with data C3,C4,C5,C6, then IDLE.
REQ-037 key0 press, model returns written data -> DONE, pass=1, err_cnt=0, disp_digits=0x00AAC3C3.
REQ-038 Model corrupts byte 2 (returns 00) -> err_cnt=1, pass=0; key2 twice -> disp_digits=0x02AAC500.
REQ-039 key0 and key1 pressed same cycle -> write sequence with gen=1 (C4..C7), no read issued.
REQ-040 ee_ready held low after write request -> timeout_err=1 after TIMEOUT cycles, DONE, pass=0.
REQ-041 rst asserted during RD_WAIT -> all outputs at reset values next edge; after release, auto-write restarts at 0x03.
